// File: rtl/lpc_cycle_sequencer.sv
// LPC I/O-cycle target sequencer. Follows LFRAME#/LAD framing, decodes a
// 16-bit I/O address against a 256-byte window and steps a claimed cycle
// through turnaround, SYNC and data phases. All outputs are registered and
// aligned with the one-hot State vector.
module lpc_cycle_sequencer #(
  parameter logic [15:0] BASE_ADDR   = 16'h0C00,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        LpcClock,
  input  logic        PciReset,
  input  logic        LpcFrame_n,
  input  logic [3:0]  LpcAd,
  output logic [12:0] State,
  output logic        Opcode,
  output logic [7:0]  AddrReg,
  output logic        Hit,
  output logic [7:0]  WrData,
  output logic        WrStrobe,
  output logic        RdStrobe,
  output logic        SyncLong
);

  // One-hot encoding doubles as the State output bit map.
  typedef enum logic [12:0] {
    ST_IDLE   = 13'h0001,
    ST_CYC    = 13'h0002,
    ST_A3     = 13'h0004,
    ST_A2     = 13'h0008,
    ST_A1     = 13'h0010,
    ST_A0     = 13'h0020,
    ST_TAR_H1 = 13'h0040,
    ST_TAR_H2 = 13'h0080,
    ST_SYNC   = 13'h0100,
    ST_DATA_L = 13'h0200,
    ST_DATA_H = 13'h0400,
    ST_TAR_P1 = 13'h0800,
    ST_TAR_P2 = 13'h1000
  } state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [7:0] BASE_HI   = BASE_ADDR[15:8];

  state_e      state_q, state_d;
  logic        opcode_q, opcode_d;
  logic [7:0]  addr_hi_q, addr_hi_d;
  logic [7:0]  addr_reg_q, addr_reg_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        hit_q, hit_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic        rd_strobe_q, rd_strobe_d;
  logic        sync_long_q, sync_long_d;
  logic        abort;

  // Next-state, capture and registered-output computation.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    opcode_d    = opcode_q;
    addr_hi_d   = addr_hi_q;
    addr_reg_d  = addr_reg_q;
    wr_data_d   = wr_data_q;
    wait_cnt_d  = wait_cnt_q;
    sync_long_d = 1'b0;

    // LFRAME# asserted mid-cycle abandons the cycle; only a START nibble
    // restarts framing, anything else drops back to IDLE.
    abort = !LpcFrame_n && (state_q != ST_IDLE) && (state_q != ST_CYC);

    if (abort) begin
      state_d = (LpcAd == 4'h0) ? ST_CYC : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (!LpcFrame_n && LpcAd == 4'h0) state_d = ST_CYC;
        ST_CYC: begin
          if (!LpcFrame_n) begin
            state_d = (LpcAd == 4'h0) ? ST_CYC : ST_IDLE;
          end else if (LpcAd == 4'h0) begin
            opcode_d = 1'b0;
            state_d  = ST_A3;
          end else if (LpcAd == 4'h2) begin
            opcode_d = 1'b1;
            state_d  = ST_A3;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_A3: begin
          addr_hi_d[7:4] = LpcAd;
          state_d        = ST_A2;
        end
        ST_A2: begin
          addr_hi_d[3:0] = LpcAd;
          state_d        = ST_A1;
        end
        ST_A1: begin
          addr_reg_d[7:4] = LpcAd;
          state_d         = ST_A0;
        end
        ST_A0: begin
          addr_reg_d[3:0] = LpcAd;
          if (addr_hi_q == BASE_HI) state_d = opcode_q ? ST_DATA_L : ST_TAR_H1;
          else                      state_d = ST_IDLE;
        end
        ST_TAR_H1: begin
          wait_cnt_d = WAIT_LOAD;
          state_d    = ST_TAR_H2;
        end
        ST_TAR_H2: begin
          sync_long_d = (wait_cnt_q != 4'd0);
          state_d     = ST_SYNC;
        end
        ST_SYNC: begin
          if (wait_cnt_q != 4'd0) begin
            wait_cnt_d  = wait_cnt_q - 4'd1;
            sync_long_d = (wait_cnt_q != 4'd1);
          end else begin
            state_d = opcode_q ? ST_TAR_P1 : ST_DATA_L;
          end
        end
        ST_DATA_L: begin
          if (opcode_q) wr_data_d[3:0] = LpcAd;
          state_d = ST_DATA_H;
        end
        ST_DATA_H: begin
          if (opcode_q) wr_data_d[7:4] = LpcAd;
          state_d = opcode_q ? ST_TAR_H1 : ST_TAR_P1;
        end
        ST_TAR_P1: state_d = ST_TAR_P2;
        ST_TAR_P2: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    // Strobes mark the clock the sequencer sits in TAR_H1; Hit covers the
    // claimed span from TAR_H1 until the cycle ends or is aborted.
    rd_strobe_d = (state_q == ST_A0)      && (state_d == ST_TAR_H1);
    wr_strobe_d = (state_q == ST_DATA_H)  && (state_d == ST_TAR_H1);
    hit_d       = (state_d == ST_TAR_H1) ||
                  (hit_q && (state_d != ST_IDLE) && (state_d != ST_CYC));
  end

  // State and output registers; reset abandons any cycle in flight.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state_q     <= ST_IDLE;
      opcode_q    <= 1'b0;
      addr_hi_q   <= 8'h00;
      addr_reg_q  <= 8'h00;
      wr_data_q   <= 8'h00;
      wait_cnt_q  <= 4'd0;
      hit_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      sync_long_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      addr_hi_q   <= addr_hi_d;
      addr_reg_q  <= addr_reg_d;
      wr_data_q   <= wr_data_d;
      wait_cnt_q  <= wait_cnt_d;
      hit_q       <= hit_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      sync_long_q <= sync_long_d;
    end
  end

  assign State    = state_q;
  assign Opcode   = opcode_q;
  assign AddrReg  = addr_reg_q;
  assign Hit      = hit_q;
  assign WrData   = wr_data_q;
  assign WrStrobe = wr_strobe_q;
  assign RdStrobe = rd_strobe_q;
  assign SyncLong = sync_long_q;

endmodule

// File: tb/tb_lpc_cycle_sequencer.sv
// Bench for lpc_cycle_sequencer. Two instances (no wait states and three
// wait states) share the bus. Each LPC transaction is expanded into the
// expected phase timeline from the cycle rules, then compared clock by clock.
module tb_lpc_cycle_sequencer;

  localparam int L = 32;

  localparam logic [12:0] S_IDLE = 13'h0001, S_CYC  = 13'h0002, S_A3  = 13'h0004,
                          S_A2   = 13'h0008, S_A1   = 13'h0010, S_A0  = 13'h0020,
                          S_TH1  = 13'h0040, S_TH2  = 13'h0080, S_SYNC = 13'h0100,
                          S_DL   = 13'h0200, S_DH   = 13'h0400, S_TP1 = 13'h0800,
                          S_TP2  = 13'h1000;

  typedef struct packed {
    logic [12:0] st;
    logic        hit;
    logic        sl;
    logic        rd;
    logic        wr;
  } exp_t;

  logic        LpcClock = 1'b0;
  logic        PciReset = 1'b0;
  logic        LpcFrame_n = 1'b1;
  logic [3:0]  LpcAd = 4'hF;

  logic [12:0] st0, st3;
  logic        op0, op3, hit0, hit3, ws0, ws3, rs0, rs3, sl0, sl3;
  logic [7:0]  ar0, ar3, wd0, wd3;

  int          n_checks = 0;
  int          n_fail   = 0;

  exp_t        exp_tab [2][L];
  logic        m_op;
  logic [7:0]  m_addr, m_wr;

  lpc_cycle_sequencer #(.BASE_ADDR(16'h0C00), .WAIT_CYCLES(0)) dut0 (
    .LpcClock(LpcClock), .PciReset(PciReset), .LpcFrame_n(LpcFrame_n), .LpcAd(LpcAd),
    .State(st0), .Opcode(op0), .AddrReg(ar0), .Hit(hit0), .WrData(wd0),
    .WrStrobe(ws0), .RdStrobe(rs0), .SyncLong(sl0)
  );

  lpc_cycle_sequencer #(.BASE_ADDR(16'h0C00), .WAIT_CYCLES(3)) dut3 (
    .LpcClock(LpcClock), .PciReset(PciReset), .LpcFrame_n(LpcFrame_n), .LpcAd(LpcAd),
    .State(st3), .Opcode(op3), .AddrReg(ar3), .Hit(hit3), .WrData(wd3),
    .WrStrobe(ws3), .RdStrobe(rs3), .SyncLong(sl3)
  );

  always #15 LpcClock = ~LpcClock;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no end of test, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [12:0] st, input logic h, input logic s,
                              input logic r, input logic w);
    exp_t e;
    e.st = st; e.hit = h; e.sl = s; e.rd = r; e.wr = w;
    return e;
  endfunction

  // Expected phase after each clock of a transaction, for a target with w waits.
  task automatic build(input int d, input int w, input logic [3:0] ctype,
                       input logic [15:0] addr, input int abort_k, input logic [3:0] abort_ad);
    exp_t q[$];
    bit   is_wr = (ctype == 4'h2);
    bit   claim = (addr[15:8] == 8'h0C);
    q.push_back(mk(S_CYC, 0, 0, 0, 0));
    if (ctype == 4'h0 || ctype == 4'h2) begin
      q.push_back(mk(S_A3, 0, 0, 0, 0));
      q.push_back(mk(S_A2, 0, 0, 0, 0));
      q.push_back(mk(S_A1, 0, 0, 0, 0));
      q.push_back(mk(S_A0, 0, 0, 0, 0));
      if (claim) begin
        if (is_wr) begin
          q.push_back(mk(S_DL, 0, 0, 0, 0));
          q.push_back(mk(S_DH, 0, 0, 0, 0));
          q.push_back(mk(S_TH1, 1, 0, 0, 1));
        end else begin
          q.push_back(mk(S_TH1, 1, 0, 1, 0));
        end
        q.push_back(mk(S_TH2, 1, 0, 0, 0));
        for (int i = 0; i <= w; i++) q.push_back(mk(S_SYNC, 1, (i < w), 0, 0));
        if (!is_wr) begin
          q.push_back(mk(S_DL, 1, 0, 0, 0));
          q.push_back(mk(S_DH, 1, 0, 0, 0));
        end
        q.push_back(mk(S_TP1, 1, 0, 0, 0));
        q.push_back(mk(S_TP2, 1, 0, 0, 0));
      end
    end
    if (abort_k != 0) begin
      while (q.size() > abort_k) void'(q.pop_back());
      q.push_back(mk((abort_ad == 4'h0) ? S_CYC : S_IDLE, 0, 0, 0, 0));
    end
    while (q.size() < L) q.push_back(mk(S_IDLE, 0, 0, 0, 0));
    for (int i = 0; i < L; i++) exp_tab[d][i] = q[i];
  endtask

  task automatic check_dut(input string tag, input int d, input int j,
                           input logic [12:0] st, input logic op, input logic [7:0] ar,
                           input logic hit, input logic [7:0] wd, input logic ws,
                           input logic rs, input logic sl);
    exp_t  e = exp_tab[d][j];
    string p = $sformatf("%s.d%0d.c%0d", tag, d, j);
    check({p, ".onehot"}, 32'($onehot(st)), 32'd1);
    check({p, ".State"},    32'(st),  32'(e.st));
    check({p, ".Hit"},      32'(hit), 32'(e.hit));
    check({p, ".SyncLong"}, 32'(sl),  32'(e.sl));
    check({p, ".RdStrobe"}, 32'(rs),  32'(e.rd));
    check({p, ".WrStrobe"}, 32'(ws),  32'(e.wr));
    check({p, ".Opcode"},   32'(op),  32'(m_op));
    check({p, ".AddrReg"},  32'(ar),  32'(m_addr));
    check({p, ".WrData"},   32'(wd),  32'(m_wr));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".d0.State"}, 32'(st0), 32'(S_IDLE));
    check({tag, ".d3.State"}, 32'(st3), 32'(S_IDLE));
    check({tag, ".d0.outs"}, {8'h0, ar0, wd0, 3'b0, op0, hit0, ws0, rs0, sl0}, 32'h0);
    check({tag, ".d3.outs"}, {8'h0, ar3, wd3, 3'b0, op3, hit3, ws3, rs3, sl3}, 32'h0);
  endtask

  // One LPC transaction; abort_k != 0 pulls LFRAME# low on that clock.
  task automatic run_txn(input string tag, input logic [3:0] ctype, input logic [15:0] addr,
                         input logic [7:0] data, input int abort_k, input logic [3:0] abort_ad);
    logic [3:0] nib [8];
    bit         valid = (ctype == 4'h0 || ctype == 4'h2);
    nib[0] = 4'h0;        nib[1] = ctype;
    nib[2] = addr[15:12]; nib[3] = addr[11:8];
    nib[4] = addr[7:4];   nib[5] = addr[3:0];
    nib[6] = data[3:0];   nib[7] = data[7:4];
    build(0, 0, ctype, addr, abort_k, abort_ad);
    build(1, 3, ctype, addr, abort_k, abort_ad);
    for (int j = 0; j < L; j++) begin
      @(negedge LpcClock);
      // NOTE: bench drives inputs with blocking assignments away from the
      // active edge, so the DUT sees them settled at the next rising edge.
      if (abort_k != 0 && j == abort_k) begin
        LpcFrame_n = 1'b0; LpcAd = abort_ad;
      end else if (abort_k != 0 && j > abort_k) begin
        LpcFrame_n = 1'b1; LpcAd = 4'hF;
      end else if (j == 0) begin
        LpcFrame_n = 1'b0; LpcAd = 4'h0;
      end else if (j < 8) begin
        LpcFrame_n = 1'b1; LpcAd = nib[j];
      end else begin
        LpcFrame_n = 1'b1; LpcAd = 4'($urandom_range(15, 0));
      end
      @(posedge LpcClock);
      #1;
      if (valid && (abort_k == 0 || j < abort_k)) begin
        if (j == 1) m_op = (ctype == 4'h2);
        if (j == 4) m_addr[7:4] = addr[7:4];
        if (j == 5) m_addr[3:0] = addr[3:0];
        if (ctype == 4'h2 && addr[15:8] == 8'h0C) begin
          if (j == 6) m_wr[3:0] = data[3:0];
          if (j == 7) m_wr[7:4] = data[7:4];
        end
      end
      check_dut(tag, 0, j, st0, op0, ar0, hit0, wd0, ws0, rs0, sl0);
      check_dut(tag, 1, j, st3, op3, ar3, hit3, wd3, ws3, rs3, sl3);
    end
  endtask

  task automatic drive(input logic f, input logic [3:0] a);
    @(negedge LpcClock);
    LpcFrame_n = f;
    LpcAd      = a;
    @(posedge LpcClock);
    #1;
  endtask

  initial begin
    logic [3:0]  ctype, ad;
    logic [15:0] addr;
    int          k, n0;

    m_op = 1'b0; m_addr = 8'h00; m_wr = 8'h00;

    // Reset state
    repeat (2) @(posedge LpcClock);
    #1;
    check_reset("reset");
    @(negedge LpcClock);
    PciReset = 1'b1;

    // Directed cycles
    run_txn("rd_hit",      4'h0, 16'h0C35, 8'h00, 0, 4'h0);
    run_txn("wr_hit",      4'h2, 16'h0C7A, 8'hA5, 0, 4'h0);
    run_txn("miss",        4'h0, 16'h0D10, 8'h00, 0, 4'h0);
    run_txn("wr_miss",     4'h2, 16'h0D10, 8'h3C, 0, 4'h0);
    run_txn("abort_a2",    4'h0, 16'h0C44, 8'h00, 3, 4'hF);
    run_txn("abort_rd_dl", 4'h0, 16'h0C12, 8'h00, 9, 4'h0);
    run_txn("abort_wr_dl", 4'h2, 16'h0C66, 8'h5A, 6, 4'h0);
    run_txn("bad_cyc",     4'h4, 16'h0C35, 8'h00, 0, 4'h0);

    // Asynchronous reset while the three-wait target is in SYNC
    drive(1'b0, 4'h0); drive(1'b1, 4'h0); drive(1'b1, 4'h0); drive(1'b1, 4'hC);
    drive(1'b1, 4'h3); drive(1'b1, 4'h5); drive(1'b1, 4'hF); drive(1'b1, 4'hF);
    check("rst_sync.d3.State",    32'(st3), 32'(S_SYNC));
    check("rst_sync.d3.SyncLong", 32'(sl3), 32'd1);
    #5;
    PciReset = 1'b0;
    #1;
    check_reset("rst_sync");
    m_op = 1'b0; m_addr = 8'h00; m_wr = 8'h00;
    @(negedge LpcClock);
    PciReset = 1'b1;
    drive(1'b1, 4'h0);
    check_reset("after_rst");

    // Randomized cycles
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(9, 0);
      if (k < 4)      ctype = 4'h0;
      else if (k < 8) ctype = 4'h2;
      else begin
        ctype = 4'($urandom_range(15, 0));
        if (ctype == 4'h0 || ctype == 4'h2) ctype = 4'h4;
      end
      addr = 16'($urandom_range(65535, 0));
      if ($urandom_range(3, 0) != 0) addr[15:8] = 8'h0C;
      n0 = (addr[15:8] == 8'h0C) ? 11 : 4;
      k  = 0;
      ad = 4'h0;
      if ((ctype == 4'h0 || ctype == 4'h2) && $urandom_range(3, 0) == 0) begin
        k  = $urandom_range(n0 + 1, 2);
        ad = $urandom_range(1, 0) ? 4'h0 : 4'($urandom_range(15, 1));
      end
      run_txn($sformatf("rand%0d", t), ctype, addr, 8'($urandom_range(255, 0)), k, ad);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
